// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID->EX register stage with RAW forwarding, hazard stall and bubble insertion.
// Define OPERAND_FORWARD_EN to forward from EX/MEM and MEM/WB; otherwise dependents wait for the register bank.
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_regWrite_i,
  input  logic              id_memRead_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DATA_W-1:0] rf_data1_i,
  input  logic [DATA_W-1:0] rf_data2_i,
  input  logic              exm_regWrite_i,
  input  logic              exm_memRead_i,
  input  logic [REG_AW-1:0] exm_rd_i,
  input  logic [DATA_W-1:0] exm_data_i,
  input  logic              wb_regWrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              id_stall_o,
  output logic              ex_valid_o,
  output logic              ex_regWrite_o,
  output logic              ex_memRead_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [DATA_W-1:0] ex_opA_o,
  output logic [DATA_W-1:0] ex_opB_o
);
`ifdef OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } ex_t;
  ex_t ex_q, ex_d;
  logic own_rs, own_rt, exm_rs, exm_rt, wb_rs, wb_rt, hazard;
  logic [DATA_W-1:0] op_a, op_b;
  function automatic logic hit(input logic u, input logic [REG_AW-1:0] s,
                               input logic w, input logic [REG_AW-1:0] d);
    return u && s != '0 && w && d == s;
  endfunction
  function automatic logic [DATA_W-1:0] pick(input logic u, input logic [REG_AW-1:0] s,
                                             input logic fx, input logic fw,
                                             input logic [DATA_W-1:0] rf);
    return !u ? rf : s == '0 ? '0 : fx ? exm_data_i : fw ? wb_data_i : rf;
  endfunction
  assign own_rs = hit(id_use_rs_i, id_rs_i, ex_q.valid & ex_q.reg_write, ex_q.rd);
  assign own_rt = hit(id_use_rt_i, id_rt_i, ex_q.valid & ex_q.reg_write, ex_q.rd);
  assign exm_rs = hit(id_use_rs_i, id_rs_i, exm_regWrite_i, exm_rd_i);
  assign exm_rt = hit(id_use_rt_i, id_rt_i, exm_regWrite_i, exm_rd_i);
  assign wb_rs  = hit(id_use_rs_i, id_rs_i, wb_regWrite_i, wb_rd_i);
  assign wb_rt  = hit(id_use_rt_i, id_rt_i, wb_regWrite_i, wb_rd_i);
  // without forwarding any in-flight producer blocks the reader until it reaches the bank
  assign hazard = id_valid_i & (own_rs | own_rt | ((exm_rs | exm_rt) & (exm_memRead_i | ~FWD))
                                | ((wb_rs | wb_rt) & ~FWD));
  assign id_stall_o = hazard | (id_valid_i & ~ex_ready_i);
  assign op_a = pick(id_use_rs_i, id_rs_i, FWD & exm_rs & ~exm_memRead_i, FWD & wb_rs, rf_data1_i);
  assign op_b = pick(id_use_rt_i, id_rt_i, FWD & exm_rt & ~exm_memRead_i, FWD & wb_rt, rf_data2_i);
  always_comb begin
    ex_d = ex_q;
    if (flush_i || (ex_ready_i && hazard)) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.ctrl      = '0;
    end else if (ex_ready_i) begin
      ex_d.valid     = id_valid_i;
      ex_d.reg_write = id_valid_i & id_regWrite_i;
      ex_d.mem_read  = id_valid_i & id_memRead_i;
      ex_d.rs        = id_rs_i;
      ex_d.rt        = id_rt_i;
      ex_d.rd        = id_rd_i;
      ex_d.ctrl      = id_valid_i ? id_ctrl_i : '0;
      ex_d.op_a      = op_a;
      ex_d.op_b      = op_b;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ex_q <= '0;
    else ex_q <= ex_d;
  assign ex_valid_o    = ex_q.valid;
  assign ex_regWrite_o = ex_q.reg_write;
  assign ex_memRead_o  = ex_q.mem_read;
  assign ex_rs_o       = ex_q.rs;
  assign ex_rt_o       = ex_q.rt;
  assign ex_rd_o       = ex_q.rd;
  assign ex_ctrl_o     = ex_q.ctrl;
  assign ex_opA_o      = ex_q.op_a;
  assign ex_opB_o      = ex_q.op_b;
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Decode-to-execute pipeline stage sitting directly downstream of the register bank read ports. Captures readData1/readData2 from the register bank, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and registers operands plus control for the EX stage. Detects unresolved hazards (producer still in EX, or load in EX/MEM) and stalls decode, inserting a bubble. Honours downstream backpressure and synchronous flush.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register index width (32 registers, index 0 hardwired zero)
CTRL_W, 16, opaque decoded-control bundle carried to EX

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_rs, id_rt, id_rd  in  REG_AW  source/destination indices (id_rs/id_rt also drive register bank readRegister1/2)
id_use_rs, id_use_rt  in  1  instruction actually reads rs/rt
id_regWrite, id_memRead  in  1  instruction writes rd / is a load
id_ctrl  in  CTRL_W  decoded control passthrough
rf_data1, rf_data2  in  DATA_W  register bank readData1/readData2
exm_regWrite, exm_memRead  in  1  EX/MEM writes / holds a load
exm_rd  in  REG_AW;  exm_data  in  DATA_W  EX/MEM destination and ALU result
wb_regWrite  in  1;  wb_rd  in  REG_AW;  wb_data  in  DATA_W  MEM/WB write (same signals feed register bank writeData/writeRegister)
flush  in  1  kill instruction entering EX
ex_ready  in  1  EX accepts a new instruction this cycle
id_stall  out  1  decode must hold (combinational)
ex_valid, ex_regWrite, ex_memRead  out  1  registered
ex_rs, ex_rt, ex_rd  out  REG_AW  registered
ex_ctrl  out  CTRL_W  registered
ex_opA, ex_opB  out  DATA_W  registered resolved operands

Behaviour:
- Reset (reset_n=0, async): every registered output = 0; ex_valid=0. Release is effective at the next rising edge.
- Pass-through latency: 1 cycle, ID to EX registers.
- Source match for a source s: use_s=1, s!=0, writer regWrite=1, writer rd==s. Index 0 never matches; it always yields 0.
- Operand select per source, in priority order:
  - EX/MEM match with exm_memRead=0: take exm_data.
  - Otherwise MEM/WB match: take wb_data. This bypasses the register bank's write-on-edge and read-old-value behaviour.
  - Otherwise: take rf_data.
  - Unused source: rf_data, no hazard.
- hazard = id_valid & (match vs own EX register (ex_valid & ex_regWrite & ex_rd) | EX/MEM match with exm_memRead=1).
- id_stall = hazard | (id_valid & ~ex_ready).
- Rising-edge update, priority order:
  1. flush=1: ex_valid<=0, ex_regWrite<=0, ex_memRead<=0, ex_ctrl<=0. Applies even if ex_ready=0.
  2. ex_ready=0: all EX registers hold.
  3. hazard: bubble. ex_valid/ex_regWrite/ex_memRead/ex_ctrl <= 0; indices and operands hold.
  4. Else: capture id_* and resolved operands; ex_valid<=id_valid.
- id_valid=0 with ex_ready=1 loads a bubble.
- A stalled instruction resolves operands anew every cycle; values are never latched early.
- Back-to-back dependence on the EX producer costs exactly 1 stall cycle (then EX/MEM forward). A load producer costs 2 cycles (then MEM/WB forward).
- Reset mid-stall: pipeline empties; id_stall depends only on current inputs.

Optional Feature:
OPERAND_FORWARD_EN
- Defined: forwarding as above.
- Undefined: operands always come from rf_data. hazard = any match vs own EX register, EX/MEM, or MEM/WB (any exm_memRead). The instruction stalls until the producer has been written to the register bank; dependence on the EX producer costs 3 cycles.

Test Plan:
- Reset: reset_n=0 mid-stream -> all ex_* = 0 immediately (async), id_stall=0 when id_valid=0.
- No hazard: id_rs=3,id_rt=4, rf_data1=0x11,rf_data2=0x22, ex_ready=1 -> next cycle ex_valid=1, ex_opA=0x11, ex_opB=0x22.
- Forward priority: exm rd=5 data=0xAAAA, wb rd=5 data=0xBBBB, rf=0xCCCC, id_rs=5 -> ex_opA=0xAAAA. With exm_regWrite=0 -> 0xBBBB. With id_rs=0 -> 0.
- EX dependence: instr A writes r7 now in EX; B reads r7 -> id_stall=1 for 1 cycle, bubble (ex_valid=0). Next cycle B forwarded from exm_data=0x1234 -> ex_opA=0x1234.
- Load-use: load to r9 in EX, next reads r9 -> 2 stall cycles. Then ex_opB=wb_data=0xDEAD. With OPERAND_FORWARD_EN undefined -> 3 stall cycles, value from rf_data.
- Flush and backpressure: ex_ready=0 holds ex_* for 3 cycles with id_stall=1. flush=1 during the hold -> ex_valid=0 next edge, ex_ctrl=0.
